// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM pipeline stage: load tracking, alignment, response buffering and drop
module mem_access_stage #(
    parameter int DATA_W   = 32,
    parameter int PC_W     = 32,
    parameter int DROP_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,

    // EX -> MEM
    input  logic              es_to_ms_valid,
    input  logic [PC_W-1:0]   es_pc,
    input  logic [DATA_W-1:0] es_alu_result,
    input  logic [4:0]        es_dest,
    input  logic              es_rf_we,
    input  logic [2:0]        es_mem_op,
    input  logic              es_req_issued,
    output logic              ms_allow_in,

    // data SRAM response
    input  logic              data_sram_data_ok,
    input  logic [DATA_W-1:0] data_sram_rdata,

    // control
    input  logic              ms_flush,

    // MEM -> WB
    input  logic              ws_allow_in,
    output logic              ms_to_ws_valid,
    output logic [PC_W-1:0]   ms_pc,
    output logic [4:0]        ms_dest,
    output logic              ms_rf_we,
    output logic [DATA_W-1:0] ms_final_result,

    // ID bypass
    output logic [4:0]        ms_fwd_dest,
    output logic [DATA_W-1:0] ms_fwd_data,
    output logic              ms_fwd_stall
);

    localparam int OFF_W = $clog2(DATA_W / 8);
    localparam int CNT_W = $clog2(DROP_MAX + 1);
    localparam logic [CNT_W-1:0] DROP_FULL = CNT_W'(DROP_MAX);

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_LB    = 3'd1;
    localparam logic [2:0] OP_LH    = 3'd2;
    localparam logic [2:0] OP_LW    = 3'd3;
    localparam logic [2:0] OP_LBU   = 3'd4;
    localparam logic [2:0] OP_LHU   = 3'd5;
    localparam logic [2:0] OP_LWU   = 3'd6;
    localparam logic [2:0] OP_STORE = 3'd7;

    // stage state
    logic              valid_q;
    logic [PC_W-1:0]   pc_q;
    logic [DATA_W-1:0] alu_q;
    logic [4:0]        dest_q;
    logic              rf_we_q;
    logic [2:0]        op_q;
    logic              wait_q;
    logic              buf_valid_q;
    logic [DATA_W-1:0] buf_data_q;
    logic [CNT_W-1:0]  drop_cnt_q;
    logic [CNT_W-1:0]  drop_cnt_d;

    // handshake terms
    logic own_ok;
    logic ready_go;
    logic allow_in;
    logic handoff;
    logic drop_inc;
    logic drop_dec;

    // A response belongs to the current instruction only once all
    // responses of cancelled loads have drained.
    assign own_ok   = data_sram_data_ok && (drop_cnt_q == '0);
    assign ready_go = !wait_q || own_ok || buf_valid_q;
    assign allow_in = (!valid_q || (ready_go && ws_allow_in)) && (drop_cnt_q != DROP_FULL);
    assign handoff  = valid_q && ready_go && ws_allow_in && !ms_flush;

    // A flushed load whose response is still in flight leaves one
    // orphan response behind; count it so it can be discarded later.
    assign drop_inc = ms_flush && valid_q && wait_q && !own_ok && (drop_cnt_q != DROP_FULL);
    assign drop_dec = data_sram_data_ok && (drop_cnt_q != '0);

    assign ms_allow_in    = allow_in;
    assign ms_to_ws_valid = valid_q && ready_go && !ms_flush;
    assign ms_pc          = pc_q;
    assign ms_dest        = dest_q;
    assign ms_rf_we       = valid_q && rf_we_q;
    assign ms_fwd_dest    = (valid_q && rf_we_q) ? dest_q : 5'd0;
    assign ms_fwd_data    = ms_final_result;
    assign ms_fwd_stall   = valid_q && wait_q && !own_ok;

    // load data extraction
    logic [DATA_W-1:0] raw;
    logic [OFF_W-1:0]  off;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [31:0]       ld_word;
    logic [DATA_W-1:0] load_val;

    assign raw     = buf_valid_q ? buf_data_q : data_sram_rdata;
    assign off     = alu_q[OFF_W-1:0];
    assign ld_byte = 8'(raw >> {off, 3'b000});
    assign ld_half = 16'(raw >> {off[OFF_W-1:1], 4'b0000});

    if (DATA_W == 64) begin : g_word64
        assign ld_word = 32'(raw >> {off[OFF_W-1], 5'b00000});
    end else begin : g_word32
        assign ld_word = raw[31:0];
    end

    // Select and extend the addressed field; non-loads pass the ALU result.
    always_comb begin
        load_val = alu_q;
        case (op_q)
            OP_LB:    load_val = DATA_W'($signed(ld_byte));
            OP_LBU:   load_val = DATA_W'(ld_byte);
            OP_LH:    load_val = DATA_W'($signed(ld_half));
            OP_LHU:   load_val = DATA_W'(ld_half);
            OP_LW:    load_val = DATA_W'($signed(ld_word));
            OP_LWU:   load_val = DATA_W'(ld_word);
            OP_NONE,
            OP_STORE: load_val = alu_q;
            default:  load_val = alu_q;
        endcase
    end

    assign ms_final_result = load_val;

    // Stage valid: loads from EX when the stage can accept, else a flush empties it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= 1'b0;
        end else if (allow_in) begin
            valid_q <= es_to_ms_valid;
        end else if (ms_flush) begin
            valid_q <= 1'b0;
        end
    end

    // Stage payload captured with each accepted instruction.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q    <= '0;
            alu_q   <= '0;
            dest_q  <= '0;
            rf_we_q <= 1'b0;
            op_q    <= OP_NONE;
        end else if (allow_in && es_to_ms_valid) begin
            pc_q    <= es_pc;
            alu_q   <= es_alu_result;
            dest_q  <= es_dest;
            rf_we_q <= es_rf_we;
            op_q    <= es_mem_op;
        end
    end

    // Outstanding-request flag: set on accept of an issued request,
    // cleared by its own response or by a flush.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wait_q <= 1'b0;
        end else if (allow_in) begin
            wait_q <= es_to_ms_valid && es_req_issued;
        end else if (ms_flush || own_ok) begin
            wait_q <= 1'b0;
        end
    end

    // Response buffer holds returned data while WB back-pressures.
    always_ff @(posedge clk) begin
        if (!rst) begin
            buf_valid_q <= 1'b0;
            buf_data_q  <= '0;
        end else if (ms_flush || handoff) begin
            buf_valid_q <= 1'b0;
        end else if (valid_q && wait_q && own_ok && !ws_allow_in) begin
            buf_valid_q <= 1'b1;
            buf_data_q  <= data_sram_rdata;
        end
    end

    // Orphan response counter; simultaneous increment and decrement cancel.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop_inc && !drop_dec) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end else if (drop_dec && !drop_inc) begin
            drop_cnt_d = drop_cnt_q - CNT_W'(1);
        end
    end

    // Drop counter register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Parametrised memory-access (MEM) pipeline stage that sits between EX and WB. It tracks an outstanding data-SRAM request issued in EX and stalls until `data_sram_data_ok` returns. It aligns and sign/zero-extends load data for byte, half and word loads, and buffers returned data while WB back-pressures. On flush it drops the response of a cancelled load, and it exports a forwarding port for the ID-stage bypass.

## Interface
Parameters:
- `DATA_W`, default 32: datapath width; legal values 32 or 64.
- `PC_W`, default 32: PC width.
- `DROP_MAX`, default 3: maximum number of cancelled responses still pending; sets the drop counter width.

Ports (clock and reset first):
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, synchronous, active-low.
- `es_to_ms_valid`, in, 1: EX holds a valid instruction.
- `es_pc`, in, PC_W: instruction PC.
- `es_alu_result`, in, DATA_W: ALU result, or the memory address for loads and stores.
- `es_dest`, in, 5: destination register.
- `es_rf_we`, in, 1: register write enable.
- `es_mem_op`, in, 3: memory operation; 0 none, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 LWU (64-bit only), 7 store.
- `es_req_issued`, in, 1: the SRAM request for this instruction was accepted in EX; a `data_ok` will follow.
- `ms_allow_in`, out, 1: MEM can accept from EX this cycle.
- `data_sram_data_ok`, in, 1: response strobe; responses return in order.
- `data_sram_rdata`, in, DATA_W: response data, valid with `data_ok`.
- `ms_flush`, in, 1: cancel the instruction held in MEM.
- `ws_allow_in`, in, 1: WB can accept.
- `ms_to_ws_valid`, out, 1: a result is presented to WB.
- `ms_pc`, out, PC_W: registered PC.
- `ms_dest`, out, 5: registered destination.
- `ms_rf_we`, out, 1: registered write enable, gated by `ms_valid`.
- `ms_final_result`, out, DATA_W: value to write back.
- `ms_fwd_dest`, out, 5: bypass destination; 0 when invalid or `rf_we`=0.
- `ms_fwd_data`, out, DATA_W: bypass data, equal to `ms_final_result`.
- `ms_fwd_stall`, out, 1: MEM holds a load whose data has not yet arrived.

## Operation
- State: `ms_valid`, stage registers, `wait_data`, data buffer `buf_data`/`buf_valid`, drop counter `drop_cnt` (0..DROP_MAX).
- `wait_data` is set on accept when `es_req_issued`=1. It clears when an own `data_ok` arrives, i.e. `data_ok` while `drop_cnt`=0.
- `ms_ready_go` = !`wait_data` || own `data_ok` this cycle || `buf_valid`.
- `ms_allow_in` = (!`ms_valid` || (`ms_ready_go` && `ws_allow_in`)) && `drop_cnt` != DROP_MAX.
- `ms_to_ws_valid` = `ms_valid` && `ms_ready_go` && !`ms_flush`.
- `ms_valid` updates only when `ms_allow_in`=1, loading `es_to_ms_valid`. Otherwise it holds, except that `ms_flush` clears it.
- Own `data_ok` while `ws_allow_in`=0: `rdata` is captured into `buf_data` and `buf_valid` is set. `buf_valid` clears on handoff to WB.
- Load extraction on the raw word R (buffer if `buf_valid`, else `rdata`), with `off` = `alu_result[log2(DATA_W/8)-1:0]`:
  - LB/LBU: byte `off`.
  - LH/LHU: halfword `off>>1`.
  - LW/LWU: word `off>>2` (64-bit); for 32-bit LW, R as-is.
  - Extension: LB/LH/LW sign-extend to DATA_W; LBU/LHU/LWU zero-extend.
  - Misaligned addresses take the aligned-down field; exceptions are handled upstream.
- Non-load ops: `ms_final_result` = `alu_result`. A store with `es_req_issued`=1 still waits for its `data_ok`.
- Flush:
  - `ms_valid` and `buf_valid` clear next cycle.
  - If `wait_data`=1 and no own `data_ok` arrives in the flush cycle, `drop_cnt` increments and `wait_data` clears.
  - A flush with an own `data_ok` in the same cycle consumes that response; no increment.
- `data_ok` while `drop_cnt`>0 decrements `drop_cnt` and is discarded. The current instruction keeps waiting.
- Increment and decrement in the same cycle leave `drop_cnt` unchanged.

## Timing
- Reset (`rst`=0 at a clk edge):
  - `ms_valid`, `wait_data`, `buf_valid`, `drop_cnt` all go to 0.
  - Outputs: `ms_to_ws_valid`=0, `ms_allow_in`=1, `ms_fwd_dest`=0, `ms_fwd_stall`=0.
  - Reset overrides flush and `data_ok` in the same cycle.
- Non-memory instruction: enters MEM at edge N and is presented to WB in cycle N (0 extra latency).
- Load: presented in the cycle its `data_ok` arrives (combinational `rdata` path), or from the buffer in later cycles.
- An instruction handed to WB at edge M is replaced by EX's instruction at the same edge (full throughput).
- `ms_fwd_stall` = `ms_valid` && `wait_data` && no own `data_ok` this cycle.

## Test plan
- Back-to-back ALU ops, PC 0x1c000000/04/08, `ws_allow_in`=1 -> one `ms_to_ws_valid` per cycle, results equal to `alu_result`; no bubbles.
- LB, addr 0x...3, `data_ok` 2 cycles after entry, `rdata`=0x80FF1234 -> `ms_fwd_stall` high for 2 cycles, then result 0xFFFFFF80; LBU of the same -> 0x00000080; LH, addr 0x...2 -> 0xFFFF80FF.
- `DATA_W`=64 LWU, addr 0x...4, `rdata`=0xDEADBEEF_00000001 -> 0x00000000_DEADBEEF; LW -> 0xFFFFFFFF_DEADBEEF.
- `data_ok` while `ws_allow_in`=0 for 3 cycles, `rdata` changing afterwards -> buffered value delivered once `ws_allow_in`=1; `ms_allow_in`=0 meanwhile.
- Flush a waiting load, next load enters, two `data_ok` arrive (0x11111111, 0x22222222) -> the first is dropped, the second load returns 0x22222222. With `drop_cnt`=DROP_MAX, `ms_allow_in`=0.
- Assert reset while waiting with `drop_cnt`=2 -> all state cleared; a subsequent LW with `data_ok` completes normally.
